// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Helpers shared across the FIFO family. Provides the pointer and occupancy
//   widths derived from the depth, and the parameter legality predicates. Each
//   FIFO top evaluates the predicates at elaboration time.
//   No ports; this is a package only.
// -----------------------------------------------------------------------------
package fifo_pkg;

    // Pointer width: log2 of the depth. The pointers wrap naturally at DEPTH.
    function automatic int unsigned addr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Occupancy width: one extra bit, so that count can hold the value DEPTH.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // DEPTH must be a power of two, at least 2, for the pointers to wrap naturally.
    function automatic bit is_pow2(input int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    // Each threshold must lie inside its range, and the empty side must sit
    // strictly below the full side.
    function automatic bit levels_legal(input int unsigned depth,
                                        input int unsigned af_level,
                                        input int unsigned ae_level);
        return (af_level >= 1) && (af_level <= depth) &&
               (ae_level <= depth - 1) && (ae_level < af_level);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
//   Storage of DEPTH words of DATA_W bits. It has one synchronous write port
//   and one synchronous read port. The read port has a registered output.
//   The array itself is never reset. Only the read register is reset, so that
//   the FIFO output reads zero after reset.
//   A read and a write to the same address on the same edge return the old
//   word. This is the read-before-write behaviour the FIFO relies on when it
//   is full and gets a simultaneous read and write.
// Ports
//   clk    in   1       clock
//   rst    in   1       async active-high reset (read register only)
//   we     in   1       write enable
//   waddr  in   ADDR_W  write address
//   wdata  in   DATA_W  write data
//   re     in   1       read enable; rdata holds its value when re is low
//   raddr  in   ADDR_W  read address
//   rdata  out  DATA_W  registered read data
// -----------------------------------------------------------------------------
module fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
//   Parametrised single-clock FIFO with active-low strobes. It reports the
//   occupancy count and programmable almost-full and almost-empty flags. It
//   pulses over_flow or under_flow for one cycle when a write or read is
//   rejected, and keeps sticky copies of those errors.
// Ports
//   clk, rst                      clock, async active-high reset
//   wr_n, rd_n                    active-low write / read strobes
//   data_in [DATA_W]              write data
//   clr_err                       synchronous clear of the sticky flags
//   data_out [DATA_W]             registered read data (1-cycle latency)
//   full, empty                   count == DEPTH / count == 0
//   almost_full, almost_empty     count >= AF_LEVEL / count <= AE_LEVEL
//   count [$clog2(DEPTH)+1]       occupancy
//   over_flow, under_flow         1-cycle reject pulses
//   ovf_sticky, udf_sticky        sticky error flags
// -----------------------------------------------------------------------------
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_n,
    input  logic                   rd_n,
    input  logic [DATA_W-1:0]      data_in,
    input  logic                   clr_err,
    output logic [DATA_W-1:0]      data_out,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   over_flow,
    output logic                   under_flow,
    output logic                   ovf_sticky,
    output logic                   udf_sticky
);

    localparam int ADDR_W = addr_w(DEPTH);
    localparam int CNT_W  = cnt_w(DEPTH);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

    if (DATA_W < 1) begin : g_bad_width
        $error("sync_fifo_param: DATA_W must be >= 1");
    end
    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two >= 2");
    end
    if (!levels_legal(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
        $error("sync_fifo_param: illegal AF_LEVEL/AE_LEVEL");
    end

    // Handshake: wr_n and rd_n are active-low strobes sampled on posedge clk.
    // A read is accepted when rd_n=0 and the FIFO is not empty. A write is
    // accepted when wr_n=0 and the FIFO is not full, or when a read is accepted
    // on the same edge. A rejected strobe changes no state. It raises
    // over_flow or under_flow for the following cycle. There is no
    // write-to-read bypass, so a read on empty is rejected even when a write
    // arrives on the same edge.
    logic              wr_ok;
    logic              rd_ok;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count_next;

    assign rd_ok = !rd_n && !empty;
    assign wr_ok = !wr_n && (!full || rd_ok);

    always_comb begin
        count_next = count;
        unique case ({wr_ok, rd_ok})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Pointers wrap naturally from DEPTH-1 to 0 because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            count <= count_next;
        end
    end

    // The status flags are registered and decoded from the next count. They
    // therefore line up with count in the same cycle, with no combinational
    // path from the strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            full         <= (count_next == FULL_CNT);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_CNT);
            almost_empty <= (count_next <= AE_CNT);
        end
    end

    // Error pulses last one cycle. On the same edge a new error takes
    // priority over clr_err, so no event is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            over_flow  <= 1'b0;
            under_flow <= 1'b0;
            ovf_sticky <= 1'b0;
            udf_sticky <= 1'b0;
        end else begin
            over_flow  <= !wr_n && !wr_ok;
            under_flow <= !rd_n && !rd_ok;
            if (!wr_n && !wr_ok) begin
                ovf_sticky <= 1'b1;
            end else if (clr_err) begin
                ovf_sticky <= 1'b0;
            end
            if (!rd_n && !rd_ok) begin
                udf_sticky <= 1'b1;
            end else if (clr_err) begin
                udf_sticky <= 1'b0;
            end
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (data_in),
        .re    (rd_ok),
        .raddr (rd_ptr),
        .rdata (data_out)
    );

endmodule
